incr_arbiter: RTL
=================

INCR_ARBITER -- requirements
Module: incr_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter NREQ, default 4: number of requesters, range 2..8.
REQ-003 Parameter WIDTH, default 16: operand and result width.
REQ-004 Parameter INCREMENT, default 2: constant added to each operand.
REQ-005 Port clk, input, 1: clock; every register updates on its rising edge.
REQ-006 Port rst_n, input, 1: synchronous active-low reset, sampled on the clk rising edge.
REQ-007 Port req_valid, input, NREQ: per-requester request strobe.
REQ-008 Port req_data, input, NREQ*WIDTH: operands; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-009 Port req_ready, output, NREQ: one-hot grant/accept pulse.
REQ-010 Port rsp_valid, output, 1: a result is held.
REQ-011 Port rsp_data, output, WIDTH: result value.
REQ-012 Port rsp_id, output, $clog2(NREQ): index of the granted requester.
REQ-013 Port rsp_ready, input, 1: consumer accepts the result.
REQ-014 Port rsp_ovf, output, 1: the addition exceeded 2^WIDTH-1.
REQ-015 Port busy, output, 1: FSM is not in IDLE.

Function
REQ-016 FSM SHALL have states IDLE, CALC and RESP; encoding is free.
REQ-017 IDLE: when any req_valid bit is 1, the block SHALL assert req_ready for exactly one requester in that same cycle, capture its operand and index, and move to CALC; otherwise it SHALL stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: search starts at last_grant+1 modulo NREQ; last_grant is 0 after reset, so requester 1 has priority first.
REQ-019 A request SHALL transfer only on the cycle where req_valid[i] and req_ready[i] are both 1; a requester may drop req_valid before it is granted, with no side effect.
REQ-020 req_ready SHALL be all-zero in CALC and RESP.
REQ-021 CALC: the block SHALL register the (WIDTH+1)-bit sum operand+INCREMENT and then move to RESP; this state lasts exactly one cycle.
REQ-022 RESP: rsp_valid=1; rsp_data, rsp_id and rsp_ovf SHALL stay stable until rsp_ready=1, after which the block moves to IDLE on the next cycle.
REQ-023 Minimum request-to-request spacing SHALL be 3 cycles; a grant SHALL never be issued in the same cycle as a response handshake.
REQ-024 Without saturation, rsp_data SHALL equal the sum modulo 2^WIDTH, and rsp_ovf SHALL equal the sum's carry bit.
REQ-025 busy SHALL be 1 in CALC and RESP, and 0 in IDLE.
REQ-026 Outputs rsp_valid, rsp_data, rsp_id and rsp_ovf SHALL be registered; req_ready may be combinational from req_valid and state.

Reset
REQ-027 While rst_n=0 at a clk edge: state becomes IDLE, last_grant=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_ovf=0 and busy=0.
REQ-028 req_ready SHALL be all-zero during any cycle in which rst_n=0.
REQ-029 Reset during CALC or RESP SHALL discard the in-flight operation, and no response for it SHALL appear afterwards.

Configuration
REQ-030 Macro INCR_ARB_SATURATE_EN, when defined: on overflow, rsp_data SHALL be 2^WIDTH-1 and rsp_ovf SHALL be 1.
REQ-031 Macro INCR_ARB_SATURATE_EN, when not defined: the result SHALL wrap per REQ-024.
REQ-032 rsp_ovf SHALL be present and driven in both builds.

Verification
REQ-033 Single request: reset, then req_valid=4'b0001 with operand 14 -> req_ready=4'b0001 in the same cycle; two cycles later rsp_valid=1, rsp_data=16, rsp_id=0, rsp_ovf=0.
REQ-034 Round-robin: all four requesters held valid with operands 10/20/30/40 and rsp_ready=1 -> grant order 1,2,3,0,1; results 22,32,42,12.
REQ-035 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_data, rsp_id and rsp_ovf stable, req_ready=0 throughout; rsp_ready=1 -> IDLE on the next cycle.
REQ-036 Overflow: operand 16'hFFFF -> 16'h0001 with rsp_ovf=1 without the macro; 16'hFFFF with rsp_ovf=1 with INCR_ARB_SATURATE_EN.
REQ-037 Reset mid-op: rst_n=0 for one cycle in CALC -> rsp_valid stays 0, busy=0, and the next grant goes to requester 1 when valid.
REQ-038 Withdrawn request: requester 2 raises req_valid while the block is BUSY, then drops it before IDLE -> no grant is ever issued to requester 2.

Source files
------------

// File: rtl/incr_arbiter.sv
// Round-robin arbiter that adds a constant to the granted operand and holds the result until it is accepted.
// Optional build macro INCR_ARB_SATURATE_EN clamps overflowing results to all-ones instead of wrapping.
module incr_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 16,
  parameter int INCREMENT = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*WIDTH-1:0]     req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      rsp_valid,
  output logic [WIDTH-1:0]          rsp_data,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  input  logic                      rsp_ready,
  output logic                      rsp_ovf,
  output logic                      busy
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    last_grant_q, last_grant_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [IW-1:0]    rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic             rsp_valid_q, rsp_valid_d;

  logic             grant_found;
  logic [IW-1:0]    grant_idx;
  logic [IW-1:0]    cand_idx;
  logic [WIDTH-1:0] grant_operand;
  logic [WIDTH:0]   sum;

  // Search begins one past the last winner so every requester gets a turn.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_idx = IW'((int'(last_grant_q) + k) % NREQ);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    grant_operand = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IW'(i)) begin
        grant_operand = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    operand_d    = operand_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_valid_d  = rsp_valid_q;
    req_ready    = '0;
    sum          = '0;
    case (state_q)
      IDLE: begin
        if (grant_found && rst_n) begin
          req_ready    = NREQ'(1) << grant_idx;
          last_grant_d = grant_idx;
          operand_d    = grant_operand;
          rsp_id_d     = grant_idx;
          state_d      = CALC;
        end
      end
      CALC: begin
        sum       = {1'b0, operand_q} + (WIDTH+1)'(INCREMENT);
        rsp_ovf_d = sum[WIDTH];
`ifdef INCR_ARB_SATURATE_EN
        rsp_data_d = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
        rsp_data_d = sum[WIDTH-1:0];
`endif
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= '0;
      operand_q    <= '0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      rsp_ovf_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      operand_q    <= operand_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign busy      = (state_q != IDLE);

endmodule
